// File: rtl/cpu_mem_arbiter_if.sv
// cpu_mem_arbiter_if: fetch port, load/store port and external bus signals of the memory arbiter.
interface cpu_mem_arbiter_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_err;
  logic        dmem_req;
  logic        dmem_we;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_err;
  logic        bus_valid;
  logic        bus_we;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        stall_if;
  logic        stall_mem;
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, bus_rdata, bus_ready,
    output imem_rdata, imem_ready, imem_err, dmem_rdata, dmem_ready, dmem_err,
    output bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata, stall_if, stall_mem
  );
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata, bus_rdata, bus_ready,
    input  imem_rdata, imem_ready, imem_err, dmem_rdata, dmem_ready, dmem_err,
    input  bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares the memory bus between fetch and load/store, data first with a fetch anti-starvation streak.
// Define CPU_MEM_ARB_TIMEOUT_EN to abort grants the bus leaves unanswered for TIMEOUT_CYCLES cycles.
module cpu_mem_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic              clk,
  input logic              rst_n,
  cpu_mem_arbiter_if.slave arb
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  state_t     state;
  logic [2:0] d_streak;
  logic       cancel, tmo_hit, resp, keep, arb_ok, go_d, go_i;
  if (MAX_D_STREAK < 1 || MAX_D_STREAK > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("cpu_mem_arbiter: parameter out of range");
  end
`ifdef CPU_MEM_ARB_TIMEOUT_EN
  logic [7:0] tmo;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo <= '0;
    else tmo <= (state == IDLE || arb.bus_ready) ? '0 : tmo + 8'd1;
  assign tmo_hit = state != IDLE && !arb.bus_ready && tmo == 8'(TIMEOUT_CYCLES - 1);
`else
  assign tmo_hit = 1'b0;
`endif
  // A ready-pulse cycle does not arbitrate, so a requester still showing its finished request is not re-granted.
  assign arb_ok    = state == IDLE && !arb.imem_ready && !arb.dmem_ready;
  assign go_d      = arb_ok && arb.dmem_req && !(arb.imem_req && d_streak == 3'(MAX_D_STREAK));
  assign go_i      = arb_ok && !go_d && arb.imem_req;
  assign resp      = state != IDLE && (arb.bus_ready || tmo_hit);
  assign keep      = !cancel && (state == GRANT_I ? arb.imem_req : arb.dmem_req);
  assign arb.stall_if  = arb.imem_req & ~arb.imem_ready;
  assign arb.stall_mem = arb.dmem_req & ~arb.dmem_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      d_streak       <= '0;
      cancel         <= 1'b0;
      arb.bus_valid  <= 1'b0;
      arb.bus_we     <= 1'b0;
      arb.bus_wstrb  <= '0;
      arb.bus_addr   <= '0;
      arb.bus_wdata  <= '0;
      arb.imem_ready <= 1'b0;
      arb.imem_err   <= 1'b0;
      arb.imem_rdata <= '0;
      arb.dmem_ready <= 1'b0;
      arb.dmem_err   <= 1'b0;
      arb.dmem_rdata <= '0;
    end else begin
      arb.imem_ready <= resp && state == GRANT_I && keep;
      arb.imem_err   <= resp && state == GRANT_I && keep && tmo_hit;
      arb.dmem_ready <= resp && state == GRANT_D && keep;
      arb.dmem_err   <= resp && state == GRANT_D && keep && tmo_hit;
      if (resp && state == GRANT_I) arb.imem_rdata <= tmo_hit ? '0 : arb.bus_rdata;
      if (resp && state == GRANT_D) arb.dmem_rdata <= tmo_hit ? '0 : arb.bus_rdata;
      cancel <= state != IDLE && !resp && !keep;
      if (go_d || go_i) begin
        state         <= go_d ? GRANT_D : GRANT_I;
        arb.bus_valid <= 1'b1;
        arb.bus_we    <= go_d && arb.dmem_we;
        arb.bus_wstrb <= go_d ? arb.dmem_wstrb : 4'b0;
        arb.bus_addr  <= go_d ? arb.dmem_addr : arb.imem_addr;
        arb.bus_wdata <= go_d ? arb.dmem_wdata : 32'b0;
        d_streak      <= go_d && arb.imem_req ? d_streak + 3'(d_streak != 3'd7) : 3'd0;
      end else if (resp) begin
        state         <= IDLE;
        arb.bus_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// tb_cpu_mem_arbiter: directed scenarios, then random traffic checked against a transaction-level arbitration model.
module tb_cpu_mem_arbiter;
  localparam int MAXS = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  cpu_mem_arbiter_if ifc();
  cpu_mem_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst_n(rst_n), .arb(ifc));
  int n_chk = 0;
  int n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  // memory model: wait_sel < 0 picks 0..3 wait states per transfer, otherwise a fixed count
  int          wait_sel = 0;
  int          wait_left = 0;
  bit          prev_valid = 0;
  bit          use_force = 0;
  logic [31:0] rd_force = '0;
  always @(posedge clk) begin
    #1;
    if (ifc.bus_valid && !prev_valid) wait_left = wait_sel < 0 ? int'($urandom_range(0, 3)) : wait_sel;
    else if (ifc.bus_valid) wait_left = wait_left - 1;
    ifc.bus_ready = ifc.bus_valid && wait_left <= 0;
    ifc.bus_rdata = use_force ? rd_force : mem_f(ifc.bus_addr);
    prev_valid = ifc.bus_valid;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic set_idle();
    ifc.imem_req = 0; ifc.imem_addr = '0;
    ifc.dmem_req = 0; ifc.dmem_we = 0; ifc.dmem_wstrb = '0; ifc.dmem_addr = '0; ifc.dmem_wdata = '0;
  endtask
  task automatic do_reset();
    set_idle();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask
  task automatic wait_valid(input int n);
    for (int i = 0; i < n && !ifc.bus_valid; i++) @(negedge clk);
  endtask
  bit          ok, seen, e, pv, ireq, dreq, dwe, arb_now;
  int          ng, gnt, rdy, nrdy, streak;
  logic [9:0]  seq;
  logic [31:0] rd, fa, da, dwd;
  logic [3:0]  dws;
  initial begin
    do_reset();
    chk("rst_valid", ifc.bus_valid, 0);
    chk("rst_ready", {ifc.imem_ready, ifc.dmem_ready, ifc.imem_err, ifc.dmem_err}, 0);
    chk("rst_bus", {ifc.bus_addr, ifc.bus_wdata}, 0);
    // single fetch, zero wait states
    use_force = 1; rd_force = 32'hDEADBEEF;
    ifc.imem_req = 1; ifc.imem_addr = 32'h100;
    #1 chk("f1_stall_n", ifc.stall_if, 1);
    @(negedge clk);
    chk("f1_valid", ifc.bus_valid, 1);
    chk("f1_bus", {ifc.bus_we, ifc.bus_wstrb, ifc.bus_addr}, {5'b0, 32'h100});
    chk("f1_stall_n1", ifc.stall_if, 1);
    chk("f1_early", ifc.imem_ready, 0);
    @(negedge clk);
    chk("f1_ready", ifc.imem_ready, 1);
    chk("f1_rdata", ifc.imem_rdata, 32'hDEADBEEF);
    chk("f1_stall_n2", ifc.stall_if, 0);
    chk("f1_valid_off", ifc.bus_valid, 0);
    ifc.imem_req = 0;
    @(negedge clk);
    chk("f1_pulse", ifc.imem_ready, 0);
    use_force = 0;
    // simultaneous fetch and store: data first
    ifc.imem_req = 1; ifc.imem_addr = 32'h300;
    ifc.dmem_req = 1; ifc.dmem_we = 1; ifc.dmem_wstrb = 4'b0001; ifc.dmem_addr = 32'h2000; ifc.dmem_wdata = 32'hA5;
    @(negedge clk);
    chk("sim_dgrant", {ifc.bus_valid, ifc.bus_we, ifc.bus_wstrb, ifc.bus_addr}, {1'b1, 1'b1, 4'b0001, 32'h2000});
    chk("sim_wdata", ifc.bus_wdata, 32'hA5);
    @(negedge clk);
    chk("sim_dready", {ifc.dmem_ready, ifc.imem_ready}, 2'b10);
    ifc.dmem_req = 0;
    @(negedge clk);
    wait_valid(4);
    chk("sim_fgrant", {ifc.bus_valid, ifc.bus_we, ifc.bus_wstrb, ifc.bus_addr}, {1'b1, 5'b0, 32'h300});
    @(negedge clk);
    chk("sim_fready", {ifc.imem_ready, ifc.imem_rdata}, {1'b1, mem_f(32'h300)});
    ifc.imem_req = 0;
    @(negedge clk);
    // starvation: both ports held, fetch forced after MAXS data grants
    ifc.imem_req = 1; ifc.imem_addr = 32'h400;
    ifc.dmem_req = 1; ifc.dmem_we = 0; ifc.dmem_addr = 32'h3000;
    seq = '0; ng = 0; pv = 0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      @(negedge clk);
      if (ifc.bus_valid && !pv) begin
        seq[ng] = ifc.bus_addr == 32'h400;
        ng++;
      end
      pv = ifc.bus_valid;
    end
    chk("starve_n", ng, 10);
    chk("starve_seq", seq, 10'h210);
    do_reset();
    // cancelled fetch with wait states, then a fresh request
    wait_sel = 5;
    ifc.imem_req = 1; ifc.imem_addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    ifc.imem_req = 0;
    @(negedge clk);
    ifc.imem_req = 1; ifc.imem_addr = 32'h80;
    ng = 0; ok = 0; seen = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (ifc.imem_ready && !seen) ng++;
      if (ifc.imem_ready && seen) begin
        ok = 1;
        chk("cxl_rdata", ifc.imem_rdata, mem_f(32'h80));
      end
      if (ifc.bus_valid && ifc.bus_addr == 32'h80) seen = 1;
    end
    chk("cxl_early", ng, 0);
    chk("cxl_grant80", seen, 1);
    chk("cxl_done", ok, 1);
    ifc.imem_req = 0;
    @(negedge clk);
    // asynchronous reset while a data grant is waiting
    wait_sel = 100000;
    ifc.dmem_req = 1; ifc.dmem_we = 0; ifc.dmem_addr = 32'h5000;
    @(negedge clk);
    chk("ar_pre_valid", ifc.bus_valid, 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("ar_valid", ifc.bus_valid, 0);
    chk("ar_dready", ifc.dmem_ready, 0);
    chk("ar_addr", ifc.bus_addr, 0);
    wait_sel = 0;
    @(negedge clk);
    rst_n = 1;
    ok = 0;
    for (int c = 0; c < 12 && !ok; c++) begin
      @(negedge clk);
      if (ifc.dmem_ready) begin
        ok = 1;
        chk("ar_rdata", ifc.dmem_rdata, mem_f(32'h5000));
      end
    end
    chk("ar_done", ok, 1);
    ifc.dmem_req = 0;
    @(negedge clk);
    // unanswered bus
    wait_sel = 100000;
    ifc.dmem_req = 1; ifc.dmem_addr = 32'h6000;
    seen = 0; e = 0; rd = '1;
    for (int c = 0; c < 1000 && !seen; c++) begin
      @(negedge clk);
      if (ifc.dmem_ready) begin
        seen = 1; e = ifc.dmem_err; rd = ifc.dmem_rdata;
      end
    end
`ifdef CPU_MEM_ARB_TIMEOUT_EN
    chk("tmo_seen", seen, 1);
    chk("tmo_err", e, 1);
    chk("tmo_rdata", rd, 0);
    ifc.dmem_req = 0;
    @(negedge clk);
    chk("tmo_pulse", {ifc.dmem_ready, ifc.dmem_err}, 0);
`else
    chk("notmo_seen", seen, 0);
    chk("notmo_valid", ifc.bus_valid, 1);
`endif
    // random traffic against the arbitration model
    do_reset();
    wait_sel = -1;
    ireq = 0; dreq = 0; gnt = 0; rdy = 0; streak = 0;
    fa = '0; da = '0; dwd = '0; dwe = 0; dws = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      chk("r_iready", ifc.imem_ready, rdy == 1);
      chk("r_dready", ifc.dmem_ready, rdy == 2);
      chk("r_err", {ifc.imem_err, ifc.dmem_err}, 0);
      if (rdy == 1) chk("r_irdata", ifc.imem_rdata, mem_f(fa));
      if (rdy == 2 && !dwe) chk("r_drdata", ifc.dmem_rdata, mem_f(da));
      chk("r_stall", {ifc.stall_if, ifc.stall_mem}, {ireq && rdy != 1, dreq && rdy != 2});
      chk("r_valid", ifc.bus_valid, gnt != 0);
      if (gnt == 1) chk("r_bus_i", {ifc.bus_we, ifc.bus_wstrb, ifc.bus_addr}, {5'b0, fa});
      if (gnt == 2) chk("r_bus_d", {ifc.bus_we, ifc.bus_wstrb, ifc.bus_addr}, {dwe, dws, da});
      if (gnt == 2 && dwe) chk("r_wdata", ifc.bus_wdata, dwd);
      arb_now = gnt == 0 && rdy == 0;
      nrdy = 0;
      if (gnt != 0 && ifc.bus_ready) begin
        nrdy = gnt;
        gnt = 0;
      end
      if (rdy == 1) ireq = 0;
      if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1; fa = $urandom & ~32'h3;
      end
      if (rdy == 2) dreq = 0;
      if (!dreq && $urandom_range(0, 5) != 0) begin
        dreq = 1; da = $urandom & ~32'h3; dwe = 1'($urandom); dws = 4'($urandom); dwd = $urandom;
      end
      ifc.imem_req = ireq; ifc.imem_addr = fa;
      ifc.dmem_req = dreq; ifc.dmem_addr = da; ifc.dmem_we = dwe; ifc.dmem_wstrb = dws; ifc.dmem_wdata = dwd;
      // data wins unless fetch has waited through MAXS consecutive data grants
      if (arb_now && dreq && !(ireq && streak == MAXS)) begin
        gnt = 2;
        streak = ireq ? streak + 1 : 0;
      end else if (arb_now && ireq) begin
        gnt = 1;
        streak = 0;
      end
      rdy = nrdy;
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
